// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(1), DATA_W data bits LSB first, parity, stop(0).
// Reports data plus parity/framing errors with a one-cycle valid pulse after the stop bit.
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              par_err,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_bit_q, par_bit_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               valid_q, valid_d;
  logic               par_err_q, par_err_d;
  logic               frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;

    case (state_q)
      IDLE: begin
        if (x) begin
          state_d = DATA;
          count_d = '0;
        end
      end
      DATA: begin
        shift_d[count_q] = x;
        count_d          = count_q + 1'b1;
        if (count_q == CNT_W'(DATA_W - 1)) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        par_bit_d = x;
        state_d   = STOP;
      end
      STOP: begin
        // Always return to IDLE: a high stop bit is an error, never a new start.
        state_d     = IDLE;
        data_out_d  = shift_q;
        par_err_d   = (^shift_q) ^ par_bit_q ^ ODD_PARITY;
        frame_err_d = x;
        valid_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign par_err   = par_err_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the number of data bits per frame (legal range 2..32).
REQ-002 The block SHALL have parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port x, input, 1 bit: the serial line, one bit per clk cycle, idle level 0.
REQ-006 The block SHALL have port data_out, output, DATA_W bits: the last received data word.
REQ-007 The block SHALL have port valid, output, 1 bit: a one-cycle pulse marking frame completion.
REQ-008 The block SHALL have port par_err, output, 1 bit: parity check failed for the last frame.
REQ-009 The block SHALL have port frame_err, output, 1 bit: stop bit was not 0 for the last frame.

Function
REQ-010 The frame format SHALL be: start bit (1), then DATA_W data bits LSB first, then one parity bit, then a stop bit (0), for DATA_W+3 bits total.
REQ-011 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and all outputs SHALL be registered.
REQ-012 IDLE: x=1 SHALL move to DATA with bit counter cleared; x=0 SHALL stay in IDLE.
REQ-013 DATA: each cycle SHALL shift x into the data shift register at bit position count (LSB first) and increment the counter; after DATA_W bits it SHALL move to PARITY.
REQ-014 PARITY: the block SHALL sample x as the parity bit, then move to STOP.
REQ-015 STOP: the block SHALL sample x as the stop bit, then move to IDLE unconditionally; a stop bit of 1 SHALL NOT be taken as a new start bit.
REQ-016 Parity: with ODD_PARITY=0, par_err SHALL be 1 if the XOR of the data bits and the parity bit is 1; with ODD_PARITY=1, par_err SHALL be 1 if that XOR is 0.
REQ-017 On the edge that samples the stop bit, the block SHALL load data_out, par_err and frame_err (frame_err = stop bit) and set valid=1 for exactly one cycle.
REQ-018 Latency: valid SHALL be high in the cycle immediately after the stop-bit cycle, i.e. DATA_W+3 cycles after the start-bit cycle.
REQ-019 data_out, par_err and frame_err SHALL hold their values until the next frame completes; they are meaningful only when valid=1 or afterwards.
REQ-020 Back-to-back frames SHALL be supported: a start bit in the cycle directly after a stop bit SHALL be accepted, giving valid pulses DATA_W+3 cycles apart.
REQ-021 A frame with both errors SHALL assert par_err and frame_err together with a single valid pulse.

Reset
REQ-022 While reset=1 at a rising edge, the block SHALL set state to IDLE, clear the counter and shift register, and set data_out=0, valid=0, par_err=0 and frame_err=0.
REQ-023 Reset mid-frame SHALL abort the frame with no valid pulse, and the first rising edge with reset=0 SHALL evaluate x in IDLE.
REQ-024 Reset SHALL take priority over all other behaviour in the same cycle.

Verification (DATA_W=8 unless stated)
REQ-025 Good frame: the bench SHALL send 1, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 0, and check that valid pulses once with data_out=0xA5, par_err=0 and frame_err=0, 11 cycles after the start bit.
REQ-026 Parity error: the bench SHALL send the same frame with parity 1 and check valid=1, data_out=0xA5, par_err=1 and frame_err=0.
REQ-027 Framing error: the bench SHALL send 0x3C with parity 0 and stop 1 and check valid=1, frame_err=1, par_err=0, and that no frame starts on the following cycle while x=0.
REQ-028 Back-to-back: the bench SHALL send 0x01 (parity 1) then 0xFF (parity 0) with no idle gap and check two valid pulses 11 cycles apart, carrying data 0x01 then 0xFF, with no errors.
REQ-029 Reset mid-frame: the bench SHALL assert reset for 1 cycle after 4 data bits and check that no valid pulse occurs and all outputs are 0; a following frame 0x3C SHALL then be received correctly.
REQ-030 Odd parity: with ODD_PARITY=1, the bench SHALL send 0x00 with parity 1 and check par_err=0, then send it with parity 0 and check par_err=1.
